display_ctrl: RTL and testbench

- Refresh scheduler and frame buffer controller for the `display` row-scan block.
- Accepts full GS×GS frames from a producer through a valid/ready handshake into a back buffer.
- Swaps the back buffer into a front buffer that drives the `display` block's matrix input. Swaps happen only between sweeps.
- Generates the `display` block's enable for exactly GS cycles per sweep, then inserts a programmable blanking gap, and checks the `display` block's done flag.

---
 rtl/display_ctrl.sv | 111 +++++++++++
 tb/tb_display_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_ctrl.sv
// rtl/display_ctrl.sv - refresh scheduler and double-buffered frame store for the display row-scan block
module display_ctrl #(
  parameter int GS          = 8,
  parameter int HOLD_CYCLES = 56,
  parameter int CNT_W       = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  logic [GS*GS-1:0]   frame_i,
  input  logic               frame_valid_i,
  output logic               frame_ready_o,
  output logic [GS*GS-1:0]   matrix_o,
  output logic               e_disp_o,
  input  logic               d_disp_i,
  output logic               busy_o,
  output logic [CNT_W-1:0]   frame_cnt_o,
  output logic               err_o
);

  localparam int ROW_W  = (GS > 1) ? $clog2(GS) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(GS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_CHECK = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [ROW_W-1:0]   r_row;
  logic [HOLD_W-1:0]  r_hold;
  logic [GS*GS-1:0]   r_back;
  logic [GS*GS-1:0]   r_matrix;
  logic               r_pending;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;
  logic               w_accept;
  logic               w_swap;

  // Ready is low while a frame waits, so accept and swap never collide.
  assign w_accept = frame_valid_i & ~r_pending;
  assign w_swap   = r_pending & ((r_state == ST_IDLE) | (r_state == ST_CHECK));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (enable_i) w_state_next = ST_SCAN;
      ST_SCAN:  if (r_row == ROW_LAST) w_state_next = ST_CHECK;
      ST_CHECK: begin
        if (HOLD_CYCLES > 0) w_state_next = ST_HOLD;
        else if (enable_i)   w_state_next = ST_SCAN;
        else                 w_state_next = ST_IDLE;
      end
      ST_HOLD:  if (r_hold == HOLD_LAST) w_state_next = enable_i ? ST_SCAN : ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_row  <= '0;
      r_hold <= '0;
    end else begin
      if (r_state == ST_SCAN && r_row != ROW_LAST) r_row <= r_row + ROW_W'(1);
      else                                         r_row <= '0;
      if (r_state == ST_HOLD) r_hold <= r_hold + HOLD_W'(1);
      else                    r_hold <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_back    <= '0;
      r_matrix  <= '0;
      r_pending <= 1'b0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_back    <= frame_i;
        r_pending <= 1'b1;
      end else if (w_swap) begin
        r_matrix  <= r_back;
        r_pending <= 1'b0;
      end
      if (r_state == ST_CHECK) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (!d_disp_i) r_err <= 1'b1;
      end
    end
  end

  // Enable is decoded from the state register so reset drops it at once.
  assign e_disp_o      = (r_state == ST_SCAN);
  assign busy_o        = (r_state != ST_IDLE);
  assign frame_ready_o = ~r_pending;
  assign matrix_o      = r_matrix;
  assign frame_cnt_o   = r_cnt;
  assign err_o         = r_err;

endmodule

// File: tb/tb_display_ctrl.sv
// tb/tb_display_ctrl.sv - directed self-checking bench for display_ctrl
module tb_display_ctrl;

  localparam int GS = 8;
  localparam int HC = 4;
  localparam int CW = 16;
  localparam logic [63:0] F_FF = 64'h00000000000000FF;
  localparam logic [63:0] F_AA = {8{8'hAA}};
  localparam logic [63:0] F_55 = {8{8'h55}};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [63:0]   frame = '0;
  logic          valid = 1'b0;
  logic          ready;
  logic [63:0]   matrix;
  logic          e_disp;
  logic          d_disp;
  logic          busy;
  logic [CW-1:0] cnt;
  logic          err;
  logic          tie_low = 1'b0;
  logic [3:0]    r_idx;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  display_ctrl #(.GS(GS), .HOLD_CYCLES(HC), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .frame_i(frame),
    .frame_valid_i(valid), .frame_ready_o(ready), .matrix_o(matrix),
    .e_disp_o(e_disp), .d_disp_i(d_disp), .busy_o(busy),
    .frame_cnt_o(cnt), .err_o(err)
  );

  // Minimal row-scan partner: done is high in the cycle after GS enabled edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_idx <= '0;
    else if (e_disp) r_idx <= r_idx + 4'd1;
    else             r_idx <= '0;
  end
  assign d_disp = tie_low ? 1'b0 : (r_idx == 4'(GS));

  task automatic do_reset;
    rst_n = 1'b0; enable = 1'b0; valid = 1'b0; frame = '0; tie_low = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) $display("FAIL wait_idle: busy=%b after %0d cycles, expected 0", busy, n);
    else passes++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0; valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (e_disp !== 1'b0) $display("FAIL reset_e_disp: got %b exp 0", e_disp); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else passes++;
    checks++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b exp 1", ready); else passes++;
    checks++; if (matrix !== 64'h0) $display("FAIL reset_matrix: got %h exp 0", matrix); else passes++;
    checks++; if (cnt !== 16'h0) $display("FAIL reset_cnt: got %0d exp 0", cnt); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b exp 0", err); else passes++;
    rst_n = 1'b1;
  endtask

  task automatic test_free_run;
    logic          exp_e;
    logic [CW-1:0] exp_c;
    do_reset();
    enable = 1'b1;
    for (int j = 0; j < 26; j++) begin
      @(negedge clk);
      exp_e = ((j % 13) < 8);
      exp_c = CW'((j > 8) ? ((j > 21) ? 2 : 1) : 0);
      checks++; if (e_disp !== exp_e) $display("FAIL free_e_disp[%0d]: got %b exp %b", j, e_disp, exp_e); else passes++;
      checks++; if (cnt !== exp_c) $display("FAIL free_cnt[%0d]: got %0d exp %0d", j, cnt, exp_c); else passes++;
      checks++; if (busy !== 1'b1) $display("FAIL free_busy[%0d]: got %b exp 1", j, busy); else passes++;
      checks++; if (err !== 1'b0) $display("FAIL free_err[%0d]: got %b exp 0", j, err); else passes++;
      checks++; if (matrix !== 64'h0) $display("FAIL free_matrix[%0d]: got %h exp 0", j, matrix); else passes++;
    end
    enable = 1'b0;
    wait_idle();
  endtask

  task automatic test_frame_idle;
    do_reset();
    frame = F_FF; valid = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 1'b0) $display("FAIL idle_ready_low: got %b exp 0", ready); else passes++;
    checks++; if (matrix !== 64'h0) $display("FAIL idle_matrix_before: got %h exp 0", matrix); else passes++;
    valid = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1) $display("FAIL idle_ready_back: got %b exp 1", ready); else passes++;
    checks++; if (matrix !== F_FF) $display("FAIL idle_matrix_swap: got %h exp %h", matrix, F_FF); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b exp 0", busy); else passes++;
    enable = 1'b1;
    @(negedge clk);
    checks++; if (e_disp !== 1'b1) $display("FAIL idle_first_rise: got %b exp 1", e_disp); else passes++;
    checks++; if (matrix !== F_FF) $display("FAIL idle_matrix_scan: got %h exp %h", matrix, F_FF); else passes++;
  endtask

  task automatic test_frame_scan;
    for (int j = 1; j <= 22; j++) begin
      @(negedge clk);
      if (j == 2) begin
        frame = F_AA; valid = 1'b1;
      end
      if (j == 3) begin
        checks++; if (ready !== 1'b0) $display("FAIL scan_ready_low: got %b exp 0", ready); else passes++;
        checks++; if (matrix !== F_FF) $display("FAIL scan_matrix_hold: got %h exp %h", matrix, F_FF); else passes++;
        frame = F_55;
      end
      if (j == 8) begin
        checks++; if (e_disp !== 1'b0) $display("FAIL scan_check_e: got %b exp 0", e_disp); else passes++;
        checks++; if (matrix !== F_FF) $display("FAIL scan_matrix_check: got %h exp %h", matrix, F_FF); else passes++;
        checks++; if (ready !== 1'b0) $display("FAIL scan_ready_check: got %b exp 0", ready); else passes++;
      end
      if (j == 9) begin
        checks++; if (matrix !== F_AA) $display("FAIL scan_matrix_swap: got %h exp %h", matrix, F_AA); else passes++;
        checks++; if (ready !== 1'b1) $display("FAIL scan_ready_back: got %b exp 1", ready); else passes++;
      end
      if (j == 10) begin
        checks++; if (ready !== 1'b0) $display("FAIL scan_second_accept: got %b exp 0", ready); else passes++;
        checks++; if (matrix !== F_AA) $display("FAIL scan_matrix_hold2: got %h exp %h", matrix, F_AA); else passes++;
        valid = 1'b0;
      end
      if (j == 22) begin
        checks++; if (matrix !== F_55) $display("FAIL scan_matrix_second: got %h exp %h", matrix, F_55); else passes++;
      end
    end
    enable = 1'b0;
    wait_idle();
  endtask

  task automatic test_stop_mid_scan;
    do_reset();
    enable = 1'b1;
    for (int j = 0; j <= 13; j++) begin
      @(negedge clk);
      if (j == 3) enable = 1'b0;
      checks++; if (e_disp !== (j < 8)) $display("FAIL stop_e_disp[%0d]: got %b exp %b", j, e_disp, (j < 8)); else passes++;
      checks++; if (busy !== (j < 13)) $display("FAIL stop_busy[%0d]: got %b exp %b", j, busy, (j < 13)); else passes++;
    end
    checks++; if (cnt !== 16'd1) $display("FAIL stop_cnt: got %0d exp 1", cnt); else passes++;
  endtask

  task automatic test_err;
    do_reset();
    tie_low = 1'b1; enable = 1'b1;
    for (int j = 0; j <= 30; j++) begin
      @(negedge clk);
      if (j == 9) tie_low = 1'b0;
      checks++; if (err !== (j >= 9)) $display("FAIL err_sticky[%0d]: got %b exp %b", j, err, (j >= 9)); else passes++;
    end
    enable = 1'b0;
    wait_idle();
    rst_n = 1'b0;
    #1;
    checks++; if (err !== 1'b0) $display("FAIL err_cleared: got %b exp 0", err); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_scan;
    do_reset();
    frame = F_FF; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    for (int j = 0; j <= 18; j++) @(negedge clk);
    checks++; if (cnt !== 16'd1) $display("FAIL rst_pre_cnt: got %0d exp 1", cnt); else passes++;
    checks++; if (e_disp !== 1'b1) $display("FAIL rst_pre_e: got %b exp 1", e_disp); else passes++;
    checks++; if (matrix !== F_FF) $display("FAIL rst_pre_matrix: got %h exp %h", matrix, F_FF); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (e_disp !== 1'b0) $display("FAIL rst_async_e: got %b exp 0", e_disp); else passes++;
    checks++; if (matrix !== 64'h0) $display("FAIL rst_async_matrix: got %h exp 0", matrix); else passes++;
    checks++; if (cnt !== 16'd0) $display("FAIL rst_async_cnt: got %0d exp 0", cnt); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL rst_async_err: got %b exp 0", err); else passes++;
    checks++; if (ready !== 1'b1) $display("FAIL rst_async_ready: got %b exp 1", ready); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_async_busy: got %b exp 0", busy); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j <= 9; j++) begin
      @(negedge clk);
      checks++; if (e_disp !== (j < 8)) $display("FAIL rst_restart_e[%0d]: got %b exp %b", j, e_disp, (j < 8)); else passes++;
    end
    enable = 1'b0;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_frame_idle();
    test_frame_scan();
    test_stop_mid_scan();
    test_err();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
